// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element table for the SRAM BIST sequencer.
package sram_bist_pkg;

  // NEXT_ADDR and NEXT_ELEM are zero-cycle decisions folded into the exits of
  // WRITE and CHECK, so the state register never actually holds them.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_WAIT,
    ST_CHECK,
    ST_NEXT_ADDR,
    ST_NEXT_ELEM,
    ST_FINISH
  } state_e;

  localparam int         NUM_ELEM  = 6;
  localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEM - 1);

  typedef struct packed {
    logic down;
    logic has_read;
    logic read_bg;
    logic has_write;
    logic write_bg;
  } elem_t;

  function automatic elem_t elem_info(input logic [2:0] idx);
    elem_t e;
    e = '0;
    case (idx)
      3'd0: e = '{down: 1'b0, has_read: 1'b0, read_bg: 1'b0, has_write: 1'b1, write_bg: 1'b0};
      3'd1: e = '{down: 1'b0, has_read: 1'b1, read_bg: 1'b0, has_write: 1'b1, write_bg: 1'b1};
      3'd2: e = '{down: 1'b0, has_read: 1'b1, read_bg: 1'b1, has_write: 1'b1, write_bg: 1'b0};
      3'd3: e = '{down: 1'b1, has_read: 1'b1, read_bg: 1'b0, has_write: 1'b1, write_bg: 1'b1};
      3'd4: e = '{down: 1'b1, has_read: 1'b1, read_bg: 1'b1, has_write: 1'b1, write_bg: 1'b0};
      3'd5: e = '{down: 1'b0, has_read: 1'b1, read_bg: 1'b0, has_write: 1'b0, write_bg: 1'b0};
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic state_e first_op(input logic [2:0] idx);
    elem_t e;
    e = elem_info(idx);
    return e.has_read ? ST_READ : ST_WRITE;
  endfunction

  function automatic logic elem_down(input logic [2:0] idx);
    elem_t e;
    e = elem_info(idx);
    return e.down;
  endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Loadable up/down address counter; the direction is latched at load so the
// terminal flag never depends on the element the caller is about to enter.
module sram_bist_addr_gen #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              dir,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              terminal
);

  logic down_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr   <= '0;
      down_q <= 1'b0;
    end else if (load) begin
      addr   <= dir ? '1 : '0;
      down_q <= dir;
    end else if (step) begin
      addr <= down_q ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign terminal = down_q ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST sequencer sitting between the SRAM controller and a
// single-port macro; passes the functional port through while idle.
module sram_march_bist #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        fail_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_element,
  output logic [DATA_W-1:0] fail_syndrome,
  output logic              func_stall,
  input  logic              func_csb_n,
  input  logic              func_we_n,
  input  logic [ADDR_W-1:0] func_addr,
  input  logic [DATA_W-1:0] func_din,
  output logic              sram_csb_n,
  output logic              sram_we_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  import sram_bist_pkg::*;

  state_e            state, state_nxt;
  logic [2:0]        elem, elem_nxt;
  logic [1:0]        wait_cnt, wait_nxt;
  elem_t             cur, nxt;
  logic              leave_addr;
  logic              ag_load, ag_step, ag_dir, ag_term;
  logic [ADDR_W-1:0] ag_addr;
  logic              bist_csb_n, bist_we_n;
  logic [DATA_W-1:0] bist_din;
  logic [DATA_W-1:0] syndrome;
  logic              mismatch;

  assign cur      = elem_info(elem);
  assign nxt      = elem_info(elem_nxt);
  assign syndrome = sram_dout ^ {DATA_W{cur.read_bg}};
  assign mismatch = (state == ST_CHECK) && (syndrome != '0);

  sram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (ag_load),
    .dir      (ag_dir),
    .step     (ag_step),
    .addr     (ag_addr),
    .terminal (ag_term)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    elem_nxt   = elem;
    wait_nxt   = wait_cnt;
    leave_addr = 1'b0;
    ag_load    = 1'b0;
    ag_step    = 1'b0;
    ag_dir     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          elem_nxt  = '0;
          ag_load   = 1'b1;
          ag_dir    = elem_down(3'd0);
          state_nxt = first_op(3'd0);
        end
      end
      ST_WRITE: leave_addr = 1'b1;
      ST_READ: begin
        if (READ_LATENCY > 1) begin
          state_nxt = ST_WAIT;
          wait_nxt  = 2'(READ_LATENCY - 2);
        end else begin
          state_nxt = ST_CHECK;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == '0) state_nxt = ST_CHECK;
        else                wait_nxt  = wait_cnt - 2'd1;
      end
      ST_CHECK: begin
        if (cur.has_write) state_nxt = ST_WRITE;
        else               leave_addr = 1'b1;
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase

    // Address step / element advance, taken in the same edge as the last op.
    if (leave_addr) begin
      if (!ag_term) begin
        ag_step   = 1'b1;
        state_nxt = first_op(elem);
      end else if (elem == LAST_ELEM) begin
        state_nxt = ST_FINISH;
      end else begin
        elem_nxt  = elem + 3'd1;
        ag_load   = 1'b1;
        ag_dir    = elem_down(elem_nxt);
        state_nxt = first_op(elem_nxt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      elem          <= '0;
      wait_cnt      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_count    <= '0;
      fail_addr     <= '0;
      fail_element  <= '0;
      fail_syndrome <= '0;
      bist_csb_n    <= 1'b1;
      bist_we_n     <= 1'b1;
      bist_din      <= '0;
    end else begin
      state      <= state_nxt;
      elem       <= elem_nxt;
      wait_cnt   <= wait_nxt;
      busy       <= state_nxt inside {ST_WRITE, ST_READ, ST_WAIT, ST_CHECK};
      done       <= (state_nxt == ST_FINISH);
      bist_csb_n <= !(state_nxt inside {ST_WRITE, ST_READ});
      bist_we_n  <= (state_nxt != ST_WRITE);
      bist_din   <= (state_nxt == ST_WRITE) ? {DATA_W{nxt.write_bg}} : '0;

      if (state == ST_IDLE && start) begin
        pass          <= 1'b1;
        fail_count    <= '0;
        fail_addr     <= '0;
        fail_element  <= '0;
        fail_syndrome <= '0;
      end else if (mismatch) begin
        pass <= 1'b0;
        if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
        if (fail_count == '0) begin
          fail_addr     <= ag_addr;
          fail_element  <= elem;
          fail_syndrome <= syndrome;
        end
      end
    end
  end

  assign func_stall = busy;
  assign sram_csb_n = busy ? bist_csb_n : func_csb_n;
  assign sram_we_n  = busy ? bist_we_n  : func_we_n;
  assign sram_addr  = busy ? ag_addr    : func_addr;
  assign sram_din   = busy ? bist_din   : func_din;

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist: ideal and stuck-at memory, address
// trace, functional pass-through, ignored start, and mid-test reset.
module tb_sram_march_bist;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int N_ACC  = 320;

  logic              clk = 1'b0;
  logic              reset, start;
  logic              busy, done, pass, func_stall;
  logic [7:0]        fail_count;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_element;
  logic [DATA_W-1:0] fail_syndrome;
  logic              func_csb_n, func_we_n;
  logic [ADDR_W-1:0] func_addr;
  logic [DATA_W-1:0] func_din;
  logic              sram_csb_n, sram_we_n;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din, sram_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_march_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .fail_count    (fail_count),
    .fail_addr     (fail_addr),
    .fail_element  (fail_element),
    .fail_syndrome (fail_syndrome),
    .func_stall    (func_stall),
    .func_csb_n    (func_csb_n),
    .func_we_n     (func_we_n),
    .func_addr     (func_addr),
    .func_din      (func_din),
    .sram_csb_n    (sram_csb_n),
    .sram_we_n     (sram_we_n),
    .sram_addr     (sram_addr),
    .sram_din      (sram_din),
    .sram_dout     (sram_dout)
  );

  // Single-port memory with one-cycle read latency and an optional
  // stuck-at-1 on bit 3 of word 7.
  logic              stuck_en = 1'b0;
  logic [DATA_W-1:0] mem [32];
  logic [DATA_W-1:0] rd_q = '0;
  assign sram_dout = rd_q;

  always @(posedge clk) begin
    if (!sram_csb_n) begin
      if (!sram_we_n) mem[sram_addr] <= sram_din;
      else rd_q <= mem[sram_addr] | ((stuck_en && sram_addr == 5'd7) ? 32'h8 : 32'h0);
    end
  end

  // Expected March C- access sequence, and a monitor comparing against it.
  logic              exp_we   [N_ACC];
  logic [ADDR_W-1:0] exp_addr [N_ACC];
  logic [DATA_W-1:0] exp_din  [N_ACC];

  int   busy_cycles = 0, done_count = 0, access_count = 0, trace_err = 0, trace_idx = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (busy && !busy_prev) trace_idx = 0;
    busy_prev = busy;
    if (busy) busy_cycles++;
    if (done) done_count++;
    if (busy && !sram_csb_n) begin
      access_count++;
      if (trace_idx >= N_ACC || sram_we_n !== exp_we[trace_idx] || sram_addr !== exp_addr[trace_idx]
          || (!sram_we_n && sram_din !== exp_din[trace_idx]))
        trace_err++;
      trace_idx++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(inout int k, input logic we, input int a, input logic bg);
    exp_we[k]   = we;
    exp_addr[k] = ADDR_W'(a);
    exp_din[k]  = {DATA_W{bg}};
    k++;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Returns the negedge count (1 = first busy cycle) at which done is seen, 0 on timeout.
  task automatic wait_done(input int inject_at, output int cyc);
    cyc = 0;
    for (int n = 1; n <= 700; n++) begin
      @(negedge clk);
      start = (n == inject_at);
      if (n == 50) check("stall_while_busy", {63'd0, func_stall}, 64'd1);
      if (done) begin
        cyc = n;
        break;
      end
    end
  endtask

  int cyc, b0, d0, a0, t0;

  initial begin
    int k;
    k = 0;
    for (int a = 0; a < 32; a++) push(k, 1'b0, a, 1'b0);
    for (int a = 0; a < 32; a++) begin push(k, 1'b1, a, 1'b0); push(k, 1'b0, a, 1'b1); end
    for (int a = 0; a < 32; a++) begin push(k, 1'b1, a, 1'b0); push(k, 1'b0, a, 1'b0); end
    for (int a = 31; a >= 0; a--) begin push(k, 1'b1, a, 1'b0); push(k, 1'b0, a, 1'b1); end
    for (int a = 31; a >= 0; a--) begin push(k, 1'b1, a, 1'b0); push(k, 1'b0, a, 1'b0); end
    for (int a = 0; a < 32; a++) push(k, 1'b1, a, 1'b0);

    reset = 1'b1; start = 1'b0;
    func_csb_n = 1'b1; func_we_n = 1'b1; func_addr = '0; func_din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_pass", {63'd0, pass}, 64'd0);
    check("rst_fail_count", {56'd0, fail_count}, 64'd0);
    check("rst_fail_addr", {59'd0, fail_addr}, 64'd0);
    check("rst_fail_element", {61'd0, fail_element}, 64'd0);
    check("rst_fail_syndrome", {32'd0, fail_syndrome}, 64'd0);
    check("rst_csb_mux", {63'd0, sram_csb_n}, 64'd1);
    @(posedge clk); #1 reset = 1'b0;

    // Functional write then read while idle.
    @(posedge clk); #1;
    func_csb_n = 1'b0; func_we_n = 1'b0; func_addr = 5'd5; func_din = 32'hDEADBEEF;
    @(negedge clk);
    check("func_wr_csb", {63'd0, sram_csb_n}, 64'd0);
    check("func_wr_we", {63'd0, sram_we_n}, 64'd0);
    check("func_wr_addr", {59'd0, sram_addr}, 64'd5);
    check("func_wr_din", {32'd0, sram_din}, 64'hDEADBEEF);
    check("func_stall_idle", {63'd0, func_stall}, 64'd0);
    @(posedge clk); #1 func_we_n = 1'b1; func_din = 32'h0;
    @(negedge clk);
    check("func_rd_we", {63'd0, sram_we_n}, 64'd1);
    check("func_rd_din", {32'd0, sram_din}, 64'd0);
    @(posedge clk); #1 func_csb_n = 1'b1;
    @(negedge clk);
    check("func_rd_data", {32'd0, sram_dout}, 64'hDEADBEEF);

    // Ideal memory; a functional write held active and a second start are both ignored.
    b0 = busy_cycles; d0 = done_count; a0 = access_count; t0 = trace_err;
    func_csb_n = 1'b0; func_we_n = 1'b0; func_addr = 5'd0; func_din = 32'h5A5A5A5A;
    pulse_start();
    wait_done(100, cyc);
    func_csb_n = 1'b1; func_we_n = 1'b1;
    check("ideal_done_cycle", 64'(cyc), 64'd481);
    repeat (3) @(negedge clk);
    check("ideal_busy_cycles", 64'(busy_cycles - b0), 64'd480);
    check("ideal_done_pulses", 64'(done_count - d0), 64'd1);
    check("ideal_accesses", 64'(access_count - a0), 64'd320);
    check("ideal_trace", 64'(trace_err - t0), 64'd0);
    check("ideal_pass", {63'd0, pass}, 64'd1);
    check("ideal_fail_count", {56'd0, fail_count}, 64'd0);
    check("ideal_done_low", {63'd0, done}, 64'd0);

    // Stuck-at-1 on bit 3 of word 7.
    stuck_en = 1'b1;
    t0 = trace_err;
    pulse_start();
    wait_done(0, cyc);
    check("stuck_done_cycle", 64'(cyc), 64'd481);
    check("stuck_pass", {63'd0, pass}, 64'd0);
    check("stuck_fail_count", {56'd0, fail_count}, 64'd3);
    check("stuck_fail_element", {61'd0, fail_element}, 64'd1);
    check("stuck_fail_addr", {59'd0, fail_addr}, 64'd7);
    check("stuck_fail_syndrome", {32'd0, fail_syndrome}, 64'h8);
    check("stuck_trace", 64'(trace_err - t0), 64'd0);
    repeat (5) @(negedge clk);
    check("stuck_hold_addr", {59'd0, fail_addr}, 64'd7);

    // Reset at cycle 200, after the element-1 failure has been recorded.
    pulse_start();
    repeat (200) @(negedge clk);
    check("mid_busy", {63'd0, busy}, 64'd1);
    check("mid_fail_count", {56'd0, fail_count}, 64'd1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_csb", {63'd0, sram_csb_n}, 64'd1);
    check("abort_fail_count", {56'd0, fail_count}, 64'd0);
    check("abort_fail_addr", {59'd0, fail_addr}, 64'd0);
    check("abort_syndrome", {32'd0, fail_syndrome}, 64'd0);
    d0 = done_count;
    repeat (600) @(negedge clk);
    check("abort_no_done", 64'(done_count - d0), 64'd0);

    // Start and reset together: reset wins.
    @(posedge clk); #1 start = 1'b1; reset = 1'b1;
    @(posedge clk); #1 start = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("start_reset_busy", {63'd0, busy}, 64'd0);

    // Fresh run after the abort.
    stuck_en = 1'b0;
    t0 = trace_err;
    pulse_start();
    wait_done(0, cyc);
    check("fresh_done_cycle", 64'(cyc), 64'd481);
    check("fresh_pass", {63'd0, pass}, 64'd1);
    check("fresh_fail_count", {56'd0, fail_count}, 64'd0);
    check("fresh_trace", 64'(trace_err - t0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
